// File: rtl/axa_undo_stack_if.sv
// Handshake bundle for the AXA undo stack: push/pop/indexed-read requests and status.
// The master drives requests; the slave (the stack) returns data and occupancy.
interface axa_undo_stack_if #(
    parameter int WIDTH = 16,
    parameter int PTR_W = 4
);
    logic             push_en;
    logic [WIDTH-1:0] push_data;
    logic             pop_en;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             rd_en;
    logic [PTR_W-1:0] rd_off;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             commit;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push_en, push_data, pop_en, rd_en, rd_off, commit,
        input  pop_valid, pop_data, rd_valid, rd_data, count, empty, full,
               overflow, underflow
    );

    modport slave (
        input  push_en, push_data, pop_en, rd_en, rd_off, commit,
        output pop_valid, pop_data, rd_valid, rd_data, count, empty, full,
               overflow, underflow
    );
endinterface

// File: rtl/axa_undo_stack.sv
// Circular undo stack with registered pop / offset-read paths, commit and overflow reporting.
// Define AXA_UNDO_OVERFLOW_TRAP_EN to refuse pushes while full and make overflow sticky.
module axa_undo_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input logic               clk,
    input logic               reset,
    axa_undo_stack_if.slave   bus
);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop_valid_q;
    logic [WIDTH-1:0] pop_data_q;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             empty_c, full_c, pop_ok, ovf_pulse, wr_en, rd_hit;
    logic [PTR_W-1:0] top_idx, rd_idx, wr_idx;

    always_comb begin
        empty_c     = (count_q == '0);
        full_c      = (count_q == DEPTH_C);
        top_idx     = sp_q - ONE_P;
        rd_idx      = top_idx - bus.rd_off;
        rd_hit      = ({1'b0, bus.rd_off} < count_q);
        // Commit swallows a same-cycle pop without reporting underflow.
        pop_ok      = bus.pop_en && !bus.commit && !empty_c;
        underflow_d = bus.pop_en && !bus.commit && empty_c;

        sp_d      = sp_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        wr_idx    = sp_q;
        ovf_pulse = 1'b0;

        if (bus.commit) begin
            count_d = '0;
            if (bus.push_en) begin
                wr_en   = 1'b1;
                sp_d    = sp_q + ONE_P;
                count_d = ONE_C;
            end
        end else if (pop_ok) begin
            if (bus.push_en) begin
                // Push+pop replaces the top entry in place.
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                sp_d    = top_idx;
                count_d = count_q - ONE_C;
            end
        end else if (bus.push_en) begin
            if (full_c) begin
                ovf_pulse = 1'b1;
`ifndef AXA_UNDO_OVERFLOW_TRAP_EN
                wr_en = 1'b1;
                sp_d  = sp_q + ONE_P;
`endif
            end else begin
                wr_en   = 1'b1;
                sp_d    = sp_q + ONE_P;
                count_d = count_q + ONE_C;
            end
        end

`ifdef AXA_UNDO_OVERFLOW_TRAP_EN
        overflow_d = bus.commit ? 1'b0 : (overflow_q | ovf_pulse);
`else
        overflow_d = ovf_pulse;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            pop_valid_q <= pop_ok;
            if (pop_ok) begin
                pop_data_q <= mem[top_idx];
            end
            if (bus.rd_en) begin
                rd_valid_q <= rd_hit;
                rd_data_q  <= rd_hit ? mem[rd_idx] : '0;
            end else begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    // Storage is never cleared; only the write is gated by reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_idx] <= bus.push_data;
        end
    end

    assign bus.pop_valid = pop_valid_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty_c;
    assign bus.full      = full_c;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: doc/axa_undo_stack.md
Name: axa_undo_stack

Overview:
- Parametrised circular undo stack for the AXA pipeline, replacing the fixed 16-entry inline array.
- Register-read stage pushes destination values and land PCs; reverse-execution ALU pops restored values; Und-type operands read by offset from top; com discards history.
- Adds depth/width generalisation, occupancy tracking, overflow/underflow reporting, commit, and registered read/pop paths.

Parameters:
- WIDTH, 16, data word width in bits
- DEPTH, 16, number of entries; power of two, at least 2
- PTR_W, 4, pointer width; must equal log2(DEPTH)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- push_en  input  1  push push_data this cycle
- push_data  input  WIDTH  value to push
- pop_en  input  1  pop top entry this cycle
- pop_valid  output  1  pop_data valid (registered)
- pop_data  output  WIDTH  popped value (registered)
- rd_en  input  1  indexed read request
- rd_off  input  PTR_W  offset from top; 0 = most recent entry
- rd_valid  output  1  rd_data valid (registered)
- rd_data  output  WIDTH  indexed read result (registered)
- commit  input  1  discard all history (com)
- count  output  PTR_W+1  current occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  one-cycle pulse, or sticky with the optional feature
- underflow  output  1  one-cycle pulse: pop attempted while empty

Behaviour:
- State: storage array mem[DEPTH], top pointer sp (next free slot, PTR_W bits, wraps mod DEPTH), count.
- Reset: sp=0, count=0, pop_valid=0, pop_data=0, rd_valid=0, rd_data=0, overflow=0, underflow=0. mem is not cleared.
- empty and full are combinational from count.
- All reads observe state before the same-cycle update, matching the pipeline's read-before-write ordering.
- Indexed read: rd_en=1 → next cycle rd_data=mem[(sp-1-rd_off) mod DEPTH] and rd_valid=(rd_off<count). If rd_off≥count: rd_valid=0, rd_data=0. rd_en=0 → rd_valid=0, rd_data holds its previous value.
- Pop only: count>0 → next cycle pop_data=mem[sp-1], pop_valid=1, sp−=1, count−=1. count==0 → pop_valid=0, underflow pulses, state unchanged.
- Push only: mem[sp]=push_data, sp+=1. If count<DEPTH, count+=1. If full, the oldest entry is overwritten (circular), count stays DEPTH, overflow pulses.
- Push and pop together, count>0: pop_data=old top, mem[sp-1]=push_data, sp and count unchanged, no overflow.
- Push and pop together, count==0: pop ignored (underflow pulses), push proceeds, count=1.
- Commit: count=0, sp unchanged. Same-cycle pop is ignored with no underflow. Same-cycle push is applied after commit, giving count=1. Same-cycle rd_en reads the pre-commit state.
- Reset asserted mid-operation overrides every other input in that cycle.
- Latency: 1 cycle for pop and indexed read; count/empty/full update on the clock edge following the operation.

Optional Feature:
- Macro: AXA_UNDO_OVERFLOW_TRAP_EN.
- Defined:
  - Push while full is refused: mem, sp, and count are unchanged.
  - overflow becomes sticky and stays high until reset or commit.
  - A same-cycle push+pop while full still succeeds (replaces top).
- Undefined: overwrite-oldest behaviour with a one-cycle overflow pulse, as above.

Test Plan (DEPTH=4, WIDTH=16):
- Reset, push 0x0011, 0x0022, 0x0033; pop ×3 → pop_data 0x0033, 0x0022, 0x0011 with pop_valid=1 each; count 3→0; empty=1.
- Push 0xA, 0xB, 0xC; rd_off=0,1,2,3 → rd_data 0xC, 0xB, 0xA with rd_valid=1; off=3 → rd_valid=0, rd_data=0.
- Push 0x1..0x5 (5 pushes) → overflow pulses on the 5th push, count=4; pops return 0x5, 0x4, 0x3, 0x2, then 5th pop underflow=1, pop_valid=0. With TRAP_EN: 5th push refused, overflow sticky, pops return 0x4..0x1.
- Push 0x7, then push 0x9 and pop in the same cycle → pop_data=0x7, count=1; next pop → 0x9.
- Push 0x1, 0x2, then commit+push 0xE in one cycle → count=1; rd_off=0 → 0xE; rd_off=1 → rd_valid=0.
- Push 0x5, 0x6, assert reset with pop_en=1 → pop_valid=0, count=0, overflow=0, underflow=0.
